// File: rtl/frame_ram_arbiter.sv
// Arbitrates one single-port frame RAM between the VGA read stream (strict priority)
// and the image decrypter, and tracks write progress, starvation and bad addresses.
module frame_ram_arbiter #(
    parameter int DEPTH        = 10000,
    parameter int STARVE_LIMIT = 200
) (
    input  logic        clk_25Mhz,
    input  logic        rst,
    input  logic        vga_active,
    input  logic [15:0] vga_addr,
    output logic [7:0]  vga_data,
    output logic        vga_valid,
    input  logic        dec_req,
    input  logic        dec_we,
    input  logic [15:0] dec_addr,
    input  logic [7:0]  dec_wdata,
    output logic        dec_gnt,
    output logic [7:0]  dec_rdata,
    output logic        dec_rvalid,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    input  logic        clr,
    output logic        frame_written,
    output logic        starved,
    output logic        err_oob
);

    localparam logic [15:0] DEPTH_A = 16'(DEPTH);
    localparam int          WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        VGA_RD,
        DEC_WR,
        DEC_RD,
        NULL_RD
    } state_t;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic              vga_oob_q, vga_oob_d;
    logic              ret_oob_q, ret_oob_d;
    logic [15:0]       ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [7:0]        vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic [7:0]        dec_rdata_q, dec_rdata_d;
    logic              dec_rvalid_q, dec_rvalid_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              frame_written_q, frame_written_d;
    logic              err_oob_q, err_oob_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic vga_oob;
    logic dec_oob;
    logic write_counted;

    always_comb begin
        dec_gnt       = dec_req & ~vga_active;
        vga_oob       = (vga_addr >= DEPTH_A);
        dec_oob       = (dec_addr >= DEPTH_A);
        write_counted = dec_gnt & dec_we & ~dec_oob;

        state_d     = IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        vga_oob_d   = 1'b0;

        if (vga_active) begin
            state_d    = VGA_RD;
            ram_addr_d = vga_addr;
            vga_oob_d  = vga_oob;
        end else if (dec_req) begin
            if (dec_we) begin
                state_d     = DEC_WR;
                ram_addr_d  = dec_addr;
                ram_wdata_d = dec_wdata;
                ram_we_d    = ~dec_oob;
            end else if (dec_oob) begin
                // Out-of-range reads never touch the RAM; the return stage supplies zero.
                state_d = NULL_RD;
            end else begin
                state_d    = DEC_RD;
                ram_addr_d = dec_addr;
            end
        end

        ret_d     = state_q;
        ret_oob_d = vga_oob_q;

        vga_valid_d  = (ret_q == VGA_RD);
        vga_data_d   = vga_data_q;
        if (ret_q == VGA_RD) begin
            vga_data_d = ret_oob_q ? 8'h00 : ram_rdata;
        end

        dec_rvalid_d = (ret_q == DEC_RD) || (ret_q == NULL_RD);
        dec_rdata_d  = dec_rdata_q;
        if (ret_q == DEC_RD) begin
            dec_rdata_d = ram_rdata;
        end else if (ret_q == NULL_RD) begin
            dec_rdata_d = 8'h00;
        end

        wr_count_d = wr_count_q;
        if (write_counted && (wr_count_q != DEPTH_A)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        frame_written_d = frame_written_q | (wr_count_d == DEPTH_A);
        err_oob_d       = err_oob_q | (dec_gnt & dec_oob);
        if (clr) begin
            wr_count_d      = 16'd0;
            frame_written_d = 1'b0;
            err_oob_d       = 1'b0;
        end

        wait_d = '0;
        if (dec_req && !dec_gnt) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_25Mhz or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ret_q           <= IDLE;
            vga_oob_q       <= 1'b0;
            ret_oob_q       <= 1'b0;
            ram_addr_q      <= 16'd0;
            ram_we_q        <= 1'b0;
            ram_wdata_q     <= 8'd0;
            vga_data_q      <= 8'd0;
            vga_valid_q     <= 1'b0;
            dec_rdata_q     <= 8'd0;
            dec_rvalid_q    <= 1'b0;
            wr_count_q      <= 16'd0;
            frame_written_q <= 1'b0;
            err_oob_q       <= 1'b0;
            wait_q          <= '0;
        end else begin
            state_q         <= state_d;
            ret_q           <= ret_d;
            vga_oob_q       <= vga_oob_d;
            ret_oob_q       <= ret_oob_d;
            ram_addr_q      <= ram_addr_d;
            ram_we_q        <= ram_we_d;
            ram_wdata_q     <= ram_wdata_d;
            vga_data_q      <= vga_data_d;
            vga_valid_q     <= vga_valid_d;
            dec_rdata_q     <= dec_rdata_d;
            dec_rvalid_q    <= dec_rvalid_d;
            wr_count_q      <= wr_count_d;
            frame_written_q <= frame_written_d;
            err_oob_q       <= err_oob_d;
            wait_q          <= wait_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign ram_wdata     = ram_wdata_q;
    assign vga_data      = vga_data_q;
    assign vga_valid     = vga_valid_q;
    assign dec_rdata     = dec_rdata_q;
    assign dec_rvalid    = dec_rvalid_q;
    assign frame_written = frame_written_q;
    assign err_oob       = err_oob_q;
    assign starved       = (wait_q == WAIT_MAX);

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: behavioural RAM, a per-request reference model keyed by
// the cycle each result is due, a small vector table and hand-written corner sequences.
module tb_frame_ram_arbiter;

    localparam int DEPTH = 10000;
    localparam int LIMIT = 4;

    logic        clk_25Mhz = 1'b0;
    logic        rst;
    logic        vga_active;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        dec_req;
    logic        dec_we;
    logic [15:0] dec_addr;
    logic [7:0]  dec_wdata;
    logic        dec_gnt;
    logic [7:0]  dec_rdata;
    logic        dec_rvalid;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        clr;
    logic        frame_written;
    logic        starved;
    logic        err_oob;

    frame_ram_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_25Mhz(clk_25Mhz), .rst(rst),
        .vga_active(vga_active), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .dec_req(dec_req), .dec_we(dec_we), .dec_addr(dec_addr), .dec_wdata(dec_wdata),
        .dec_gnt(dec_gnt), .dec_rdata(dec_rdata), .dec_rvalid(dec_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .clr(clr), .frame_written(frame_written), .starved(starved), .err_oob(err_oob)
    );

    always #20 clk_25Mhz = ~clk_25Mhz;

    // Synchronous single-port RAM; out-of-range reads return a poison value.
    logic [7:0] mem [0:DEPTH-1];
    always @(posedge clk_25Mhz) begin
        if (ram_we && (ram_addr < 16'(DEPTH))) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < 16'(DEPTH)) ? mem[ram_addr] : 8'hEE;
    end

    int cyc = 0;
    always @(posedge clk_25Mhz) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model_mem [0:DEPTH-1];
    bit         exp_vv [int];
    logic [7:0] exp_vd [int];
    bit         exp_dv [int];
    logic [7:0] exp_dd [int];
    int         mwr;
    bit         mfw;
    bit         merr;
    int         mwait;

    typedef struct {
        logic        va;
        logic [15:0] vaddr;
        logic        dr;
        logic        dwe;
        logic [15:0] daddr;
        logic [7:0]  dwd;
        logic        exp_we;
        logic        chk_addr;
        logic [15:0] exp_addr;
        logic        chk_wd;
        logic [7:0]  exp_wd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_vv.delete();
        exp_vd.delete();
        exp_dv.delete();
        exp_dd.delete();
        mwr   = 0;
        mfw   = 0;
        merr  = 0;
        mwait = 0;
    endtask

    task automatic check_output();
        bit ev = exp_vv.exists(cyc);
        bit ed = exp_dv.exists(cyc);
        chk("vga_valid", vga_valid, ev);
        if (ev) chk("vga_data", vga_data, exp_vd[cyc]);
        chk("dec_rvalid", dec_rvalid, ed);
        if (ed) chk("dec_rdata", dec_rdata, exp_dd[cyc]);
        chk("starved", starved, mwait == LIMIT);
        chk("err_oob", err_oob, merr);
        chk("frame_written", frame_written, mfw);
        chk("wr_count", dut.wr_count_q, mwr);
    endtask

    task automatic apply_stimulus(input logic va, input logic [15:0] vaddr, input logic dr,
                                  input logic dwe, input logic [15:0] daddr, input logic [7:0] dwd,
                                  input logic c);
        bit oob;
        int due;
        @(negedge clk_25Mhz);
        check_output();
        vga_active = va;
        vga_addr   = vaddr;
        dec_req    = dr;
        dec_we     = dwe;
        dec_addr   = daddr;
        dec_wdata  = dwd;
        clr        = c;
        due        = cyc + 3;
        #1;
        chk("dec_gnt", dec_gnt, dr & ~va);
        if (va) begin
            exp_vv[due] = 1;
            exp_vd[due] = (vaddr < DEPTH) ? model_mem[vaddr] : 8'h00;
        end else if (dr) begin
            oob = (daddr >= DEPTH);
            if (oob) merr = 1;
            if (dwe) begin
                if (!oob) begin
                    model_mem[daddr] = dwd;
                    if (mwr < DEPTH) mwr++;
                end
            end else begin
                exp_dv[due] = 1;
                exp_dd[due] = oob ? 8'h00 : model_mem[daddr];
            end
        end
        if (mwr == DEPTH) mfw = 1;
        if (c) begin
            mwr  = 0;
            mfw  = 0;
            merr = 0;
        end
        mwait = (dr && va) ? ((mwait < LIMIT) ? mwait + 1 : LIMIT) : 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        vga_active = 0; vga_addr = 0; dec_req = 0; dec_we = 0;
        dec_addr = 0; dec_wdata = 0; clr = 0;
        rst = 1;
        clear_model();
        repeat (2) @(negedge clk_25Mhz);
        rst = 0;
    endtask

    function automatic logic [15:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 7) return 16'($urandom_range(0, 15));
        if (r < 9) return 16'(DEPTH - 2 + $urandom_range(0, 4));
        return 16'hFFFF;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'(i);
            model_mem[i] = 8'(i);
        end

        vecs[0] = '{1, 3,     0, 0, 0,     8'h00, 0, 1, 3,     0, 8'h00};
        vecs[1] = '{1, 7,     1, 1, 20,    8'h5A, 0, 1, 7,     0, 8'h00};
        vecs[2] = '{0, 0,     1, 1, 20,    8'h5A, 1, 1, 20,    1, 8'h5A};
        vecs[3] = '{0, 0,     0, 0, 0,     8'h00, 0, 1, 20,    1, 8'h5A};
        vecs[4] = '{0, 0,     1, 0, 21,    8'h00, 0, 1, 21,    0, 8'h00};
        vecs[5] = '{0, 0,     1, 1, 10000, 8'h77, 0, 0, 0,     0, 8'h00};
        vecs[6] = '{0, 0,     1, 0, 10001, 8'h00, 0, 0, 0,     0, 8'h00};
        vecs[7] = '{1, 10002, 0, 0, 0,     8'h00, 0, 1, 10002, 0, 8'h00};

        do_reset();
        #1;
        chk("reset_vga_valid", vga_valid, 0);
        chk("reset_ram_we", ram_we, 0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].va, vecs[i].vaddr, vecs[i].dr, vecs[i].dwe,
                           vecs[i].daddr, vecs[i].dwd, 0);
            @(posedge clk_25Mhz);
            #1;
            chk($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].exp_addr);
            if (vecs[i].chk_wd) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].exp_wd);
        end
        idle(3);

        // Reset between the request edge and the data-return edge.
        apply_stimulus(0, 0, 1, 0, 3, 0, 0);
        @(posedge clk_25Mhz);
        #1;
        do_reset();
        #1;
        chk("rst_vga_data", vga_data, 0);
        chk("rst_vga_valid", vga_valid, 0);
        chk("rst_dec_rdata", dec_rdata, 0);
        chk("rst_dec_rvalid", dec_rvalid, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_err_oob", err_oob, 0);
        chk("rst_starved", starved, 0);
        idle(4);

        for (int i = 0; i < 10; i++) apply_stimulus(1, 16'(i), 1, 0, 8, 0, 0);
        idle(4);

        for (int i = 0; i < 3; i++) apply_stimulus(1, 16'(i), 1, 1, 5, 8'hA5, 0);
        apply_stimulus(0, 0, 1, 1, 5, 8'hA5, 0);
        apply_stimulus(0, 0, 1, 0, 5, 0, 0);
        idle(4);
        chk("ram5_written", mem[5], 8'hA5);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1, 16'(40 + i), 1, 1, 9, 8'h3C, 0);
            @(posedge clk_25Mhz);
            #1;
            chk($sformatf("starve_wait%0d", i + 1), starved, (i + 1 >= LIMIT));
        end
        apply_stimulus(0, 0, 1, 1, 9, 8'h3C, 0);
        @(posedge clk_25Mhz);
        #1;
        chk("starve_after_grant", starved, 0);
        idle(3);

        apply_stimulus(0, 0, 1, 1, 16'd10000, 8'h33, 0);
        @(posedge clk_25Mhz);
        #1;
        chk("oob_ram_we", ram_we, 0);
        apply_stimulus(0, 0, 1, 0, 16'd10000, 0, 0);
        idle(4);
        chk("oob_sticky", err_oob, 1);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 2) == 0), rand_addr(), $urandom_range(0, 1),
                           $urandom_range(0, 1), rand_addr(), 8'($urandom),
                           ($urandom_range(0, 19) == 0));
        end
        idle(4);

        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 0, 1, 1, 16'(i), 8'(~i), 0);
        idle(2);
        chk("progress_frame_written", frame_written, 1);
        chk("progress_count", dut.wr_count_q, DEPTH);
        apply_stimulus(0, 0, 1, 1, 16'd7, 8'h11, 1);
        idle(2);
        chk("clr_frame_written", frame_written, 0);
        chk("clr_wr_count", dut.wr_count_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_ram_arbiter.md
# frame_ram_arbiter

Shares one single-port 8-bit frame RAM between the VGA display read stream and the image decrypter. The decrypter writes decrypted pixels and reads encrypted pixels through a req/gnt handshake. The display path has strict priority whenever it is inside the visible image window. The block also tracks decrypter write progress and reports starvation and out-of-range accesses.

## Interface
- DEPTH, 10000: number of pixels in the image (100x100); valid addresses are 0..DEPTH-1.
- STARVE_LIMIT, 200: number of consecutive ungranted cycles with dec_req high before `starved` asserts.
- clk_25Mhz  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- vga_active  in  1  display requests a read this cycle.
- vga_addr  in  16  display read address.
- vga_data  out  8  display read data.
- vga_valid  out  1  vga_data is valid this cycle.
- dec_req  in  1  decrypter requests an access.
- dec_we  in  1  1 = write, 0 = read; qualified by dec_req.
- dec_addr  in  16  decrypter address.
- dec_wdata  in  8  decrypter write data.
- dec_gnt  out  1  combinational grant; the transfer occurs on the edge where dec_req and dec_gnt are both high.
- dec_rdata  out  8  decrypter read data.
- dec_rvalid  out  1  dec_rdata is valid this cycle.
- ram_addr  out  16  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  8  registered RAM write data.
- ram_rdata  in  8  RAM read data; the RAM is synchronous with 1-cycle read latency.
- clr  in  1  synchronous clear of wr_count, frame_written and err_oob.
- frame_written  out  1  sticky; asserts once wr_count reaches DEPTH.
- starved  out  1  decrypter waiting time has reached STARVE_LIMIT.
- err_oob  out  1  sticky; an access with address >= DEPTH was granted.

## Operation
- The registered state is the owner of the access currently presented to the RAM:
  - IDLE: no access.
  - VGA_RD: display read.
  - DEC_WR: decrypter write.
  - DEC_RD: decrypter read.
  - NULL_RD: granted read to an out-of-range address.
- Next-state selection, evaluated every cycle in priority order:
  1. vga_active=1 gives VGA_RD.
  2. Otherwise dec_req=1 gives DEC_WR or DEC_RD according to dec_we.
  3. Otherwise IDLE.
- dec_gnt = dec_req & ~vga_active. dec_gnt never asserts while vga_active=1.
- On entering VGA_RD, DEC_WR or DEC_RD, the selected address (and data) is registered onto ram_addr and ram_wdata.
  - ram_we=1 only in DEC_WR.
  - In IDLE, ram_addr and ram_wdata hold their values and ram_we=0.
- Out-of-range address (addr >= DEPTH):
  - Decrypter: the access is still granted. ram_we is forced to 0. err_oob is set.
  - Decrypter write to an out-of-range address: nothing is written to RAM; err_oob is set.
  - Decrypter read: the state becomes NULL_RD; dec_rdata returns 0x00 with dec_rvalid.
  - VGA: vga_data returns 0x00 with vga_valid; err_oob is not set.
- Read return: a second stage registers the owner of the previous access.
  - Its cycle after the RAM samples, ram_rdata (or 0x00 for an out-of-range access) is registered to vga_data or dec_rdata.
  - The matching valid strobe pulses for one cycle.
- wr_count (16-bit):
  - Increments on each granted in-range write.
  - Saturates at DEPTH.
  - frame_written is set when wr_count reaches DEPTH.
- Wait counter:
  - Increments on each cycle with dec_req & ~dec_gnt, saturating at STARVE_LIMIT.
  - Clears on a grant or when dec_req=0.
  - starved = (wait counter == STARVE_LIMIT).
- clr:
  - Zeroes wr_count, frame_written and err_oob.
  - If clr coincides with a counted write, clr wins and wr_count becomes 0.
  - clr does not affect state or the data pipeline.
- Reset:
  - All outputs 0; state IDLE; all counters 0.
  - Reset mid-transfer drops any in-flight reads; no valid strobe follows reset.

## Timing
- Request sampled at edge E0; RAM signals driven after E0; RAM captures at E1; data and valid registered at E2.
- Read latency: valid is high in the cycle after E2, i.e. 2 cycles after the request edge. The same applies to VGA and the decrypter.
- Full throughput: one access per cycle. Back-to-back vga_active gives a continuous vga_valid stream delayed by 2 cycles.
- Write visibility: a write granted at E0 is in RAM after E1. A read granted at E1 to the same address returns the new data.
- Simultaneous vga_active and dec_req: VGA wins, dec_gnt=0, and the decrypter holds req/addr/data until granted.
- dec_gnt changes combinationally with vga_active; the decrypter samples it only at the edge.

## Test plan
- Reset mid-read: issue a decrypter read, assert rst before E2 -> dec_rvalid never pulses; all outputs are 0 after reset.
- VGA read stream:
  - Stimulus: preload RAM[n]=n[7:0]; drive vga_active with vga_addr 0..9 on consecutive cycles.
  - Required: vga_valid is high for exactly 10 cycles starting 2 cycles after the first request, with data 0x00..0x09; dec_gnt=0 throughout.
- Contention:
  - Stimulus: dec_req=1, dec_we=1, addr 5, data 0xA5, while vga_active=1 for 3 cycles.
  - Required: dec_gnt rises on the cycle vga_active falls; RAM[5]=0xA5; a subsequent decrypter read of 5 returns 0xA5 with a 2-cycle latency.
- Starvation: STARVE_LIMIT=4; hold vga_active=1 and dec_req=1 for 6 cycles -> starved asserts after the 4th waiting cycle and clears on the cycle after the grant.
- Out of range: decrypter write to addr 10000 -> granted, ram_we=0, err_oob=1, wr_count unchanged; decrypter read of 10000 -> dec_rdata=0x00 with dec_rvalid.
- Progress:
  - Stimulus: 10000 in-range writes, then clr asserted together with one more write.
  - Required: frame_written=1 after write 10000; wr_count=0 and frame_written=0 after clr.
